muldiv_sequencer: RTL

Iterative RV32M execution unit, sequenced by an internal FSM. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the main ALU in EX. It is selected when the decoder flags an R-type with Funct7 = 7'b0000001.
- Runs one shift-add (multiply) or restoring-subtract (divide) step per clock.
- Drives a stall request to the hazard unit until the result is ready.

---
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock,
// with divide-by-zero and signed-overflow divides resolved in a single cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             kill,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] Result
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic             sgn_a, sgn_b, in_neg_a, in_neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    // Accept-cycle decode: signedness, magnitudes and single-cycle divide cases
    always_comb begin
        sgn_a    = Funct3[2] ? ~Funct3[0] : (Funct3 != 3'b011);
        sgn_b    = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
        in_neg_a = sgn_a & SrcA[WIDTH-1];
        in_neg_b = sgn_b & SrcB[WIDTH-1];
        mag_a    = in_neg_a ? (~SrcA + WIDTH'(1)) : SrcA;
        mag_b    = in_neg_b ? (~SrcB + WIDTH'(1)) : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
        if (div_zero) begin
            special_res = Funct3[1] ? SrcA : '1;
        end else begin
            special_res = Funct3[1] ? '0 : SrcA;
        end
    end

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [W2-1:0]    prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, final_res;

    // Single iteration datapath plus sign fix-up of the final iteration's values
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opa_q & {WIDTH{acc_q[0]}}};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[WIDTH];
        rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {acc_q[WIDTH-2:0], div_ge};
        prod_s    = (neg_a_q ^ neg_b_q) ? (~mul_next + W2'(1)) : mul_next;
        quo_s     = (neg_a_q ^ neg_b_q) ? (~quo_next + WIDTH'(1)) : quo_next;
        rem_s     = neg_a_q ? (~rem_next + WIDTH'(1)) : rem_next;
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[W2-1:WIDTH];
        end else begin
            final_res = op_q[1] ? rem_s : quo_s;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        prev_d   = prev_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d    = Funct3;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    opa_d   = mag_a;
                    opb_d   = mag_b;
                    cnt_d   = '0;
                    rem_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, (Funct3[2] ? mag_a : mag_b)};
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        prev_d   = result_q;
                        result_d = special_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? {acc_q[W2-1:WIDTH], quo_next} : mul_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        prev_d   = result_q;
                        result_d = final_res;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A flushed result must not become architecturally visible
                if (kill) begin
                    result_d = prev_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            prev_q   <= prev_d;
        end
    end

    // Handshake outputs follow the state so the hazard unit sees busy in the accept cycle
    always_comb begin
        ready  = (state_q == S_IDLE);
        busy   = !reset && ((state_q == S_CALC) || ((state_q == S_IDLE) && start && !kill));
        valid  = !reset && !kill && (state_q == S_DONE);
        Result = result_q;
    end

endmodule
